// File: rtl/core_pkg.sv
// Shared constants for the RV32I core: datapath width, reset PC and the bubble instruction.
package core_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // Redirect targets are word aligned; the low two bits are dropped rather than trapped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/pipe_reg_en_clr.sv
// Width-generic pipeline register: synchronous active-low reset, synchronous clear, load enable.
module pipe_reg_en_clr #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  // Reset beats clear, clear beats enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else if (clr_i) begin
      q_q <= CLR_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: PC, PC+4, redirect mux and the Decode latch.
module fetch_stage
  import core_pkg::*;
#(
  parameter int            XLEN_P      = XLEN,
  parameter logic [XLEN_P-1:0] RESET_PC_P = RESET_PC,
  parameter logic [31:0]   NOP_INSTR_P = NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              PCSrcE,
  input  logic [XLEN_P-1:0] PCTargetE,
  input  logic [31:0]       InstrF,
  output logic [XLEN_P-1:0] PCF,
  output logic [31:0]       InstrD,
  output logic [XLEN_P-1:0] PCD,
  output logic [XLEN_P-1:0] PCPlus4D,
  output logic              ValidD
);
  localparam int BW = 1 + XLEN_P + XLEN_P + 32;
  localparam logic [BW-1:0] D_BUBBLE = {1'b0, {XLEN_P{1'b0}}, {XLEN_P{1'b0}}, NOP_INSTR_P};

  logic [XLEN_P-1:0] pc_q;
  logic [XLEN_P-1:0] pc_d;
  logic [XLEN_P-1:0] pc_plus4_s;
  logic [BW-1:0]     ifid_d;
  logic [BW-1:0]     ifid_q;

  assign pc_plus4_s = pc_q + XLEN_P'(4);

  // Next-PC select: a redirect from Execute overrides sequential fetch.
  always_comb begin
    pc_d = pc_plus4_s;
    if (PCSrcE) begin
      pc_d = {PCTargetE[XLEN_P-1:2], 2'b00};
    end else begin
      pc_d = pc_plus4_s;
    end
  end

  // Redirect must land even while the hazard unit holds the PC.
  pipe_reg_en_clr #(
    .W      (XLEN_P),
    .RST_VAL(RESET_PC_P),
    .CLR_VAL({XLEN_P{1'b0}})
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (~StallF | PCSrcE),
    .clr_i(1'b0),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  assign ifid_d = {1'b1, pc_plus4_s, pc_q, InstrF};

  pipe_reg_en_clr #(
    .W      (BW),
    .RST_VAL(D_BUBBLE),
    .CLR_VAL(D_BUBBLE)
  ) u_ifid_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (~StallD),
    .clr_i(FlushD),
    .d_i  (ifid_d),
    .q_o  (ifid_q)
  );

  assign PCF                            = pc_q;
  assign {ValidD, PCPlus4D, PCD, InstrD} = ifid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random control/target traffic
// checked against a behavioural pipeline model.
module tb_fetch_stage;
  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: what fetch/decode should hold after each edge.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
  logic        m_valid;

  fetch_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .InstrF   (InstrF),
    .PCF      (PCF),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  function automatic logic [31:0] imem(input logic [31:0] addr);
    return addr | 32'h0000_0A00;
  endfunction

  assign InstrF = imem(PCF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".PCF"},      PCF,             m_pc);
    chk({tag, ".InstrD"},   InstrD,          m_instr);
    chk({tag, ".PCD"},      PCD,             m_pcd);
    chk({tag, ".PCPlus4D"}, PCPlus4D,        m_pc4d);
    chk({tag, ".ValidD"},   {31'd0, ValidD}, {31'd0, m_valid});
  endtask

  // One clock: drive at negedge, advance the model at the edge, compare just after it.
  task automatic step(input string tag, input logic rst, input logic sf, input logic sd,
                      input logic fd, input logic ps, input logic [31:0] tgt);
    logic [31:0] old_pc;
    @(negedge clk);
    rst_n = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    @(posedge clk);
    old_pc = m_pc;
    if (!rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
    end else begin
      if (ps)      m_pc = (tgt / 32'd4) * 32'd4;
      else if (!sf) m_pc = old_pc + 32'd4;
      if (fd) begin
        m_instr = 32'h13; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
      end else if (!sd) begin
        m_instr = imem(old_pc); m_pcd = old_pc; m_pc4d = old_pc + 32'd4; m_valid = 1'b1;
      end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0;

    // T1: reset holds regardless of random inputs
    step("t1a", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    step("t1b", 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    chk("t1.PCF", PCF, 32'h0);
    chk("t1.InstrD", InstrD, 32'h13);

    // T2: sequential fetch
    step("t2a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t2.PCF4", PCF, 32'h4);
    chk("t2.InstrA00", InstrD, 32'hA00);
    chk("t2.PCPlus4D", PCPlus4D, 32'h4);
    chk("t2.ValidD", {31'd0, ValidD}, 32'h1);
    step("t2b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t2.PCF8", PCF, 32'h8);

    // T3: load-use stall one cycle, then resume
    step("t3a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t3.PCFheld", PCF, 32'h8);
    chk("t3.PCDheld", PCD, 32'h4);
    step("t3b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t3.PCFC", PCF, 32'hC);
    chk("t3.InstrA08", InstrD, 32'hA08);

    // T4: taken branch redirect with flush
    step("t4a", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    chk("t4.PCF40", PCF, 32'h40);
    chk("t4.bubble", InstrD, 32'h13);
    step("t4b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4.PCD40", PCD, 32'h40);
    chk("t4.ValidD", {31'd0, ValidD}, 32'h1);

    // T5: everything at once; redirect and flush dominate, target masked
    step("t5", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h103);
    chk("t5.PCF100", PCF, 32'h100);
    chk("t5.ValidD", {31'd0, ValidD}, 32'h0);

    // T6: wrap at top of address space, then reset under stall
    step("t6a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("t6b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6.wrapPCF", PCF, 32'h0);
    chk("t6.wrapPC4D", PCPlus4D, 32'h0);
    step("t6c", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("t6d", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6.rstPCF", PCF, 32'h0);
    chk("t6.rstValid", {31'd0, ValidD}, 32'h0);

    // Random traffic, including occasional mid-stream resets
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(0, 31) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0),
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
